dq4_load_ctrl: RTL
==================

# dq4_load_ctrl

Clocked load sequencer that sits directly upstream of the 4-bit D-latch array. It turns a valid/ready word stream into the latch array's `D` bus and level-sensitive `en` strobe, so every word gets guaranteed setup, pulse and hold windows. Each accepted word is presented on `D`, then `en` is pulsed high, then `D` is held stable after `en` falls. Only then can the next word be accepted.

## Interface
- `WIDTH`, 4, data width; matches the latch array width.
- `SETUP_CYC`, 1, cycles `D` is stable before `en` rises; legal range 1..15.
- `PULSE_CYC`, 1, cycles `en` is held high; legal range 1..15.
- `HOLD_CYC`, 1, cycles `D` is held after `en` falls; legal range 1..15.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  upstream word available.
- `in_data`  input  [0:WIDTH-1]  word to load; bit 0 is the MSB.
- `in_ready`  output  1  block accepts a word this cycle.
- `D`  output  [0:WIDTH-1]  data bus to the latch array.
- `en`  output  1  latch enable; latch is transparent while high.
- `busy`  output  1  a load sequence is in progress.
- `load_count`  output  8  number of completed loads, modulo 256.
- `Q`  input  [0:WIDTH-1]  latch array outputs for readback. Present only with `DQ4_LOAD_READBACK_EN`.
- `rd_err`  output  1  sticky readback mismatch flag. Present only with `DQ4_LOAD_READBACK_EN`.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD. A 4-bit phase counter `ph` times each state.
- `in_ready` = (state==IDLE) && `rst_n`. It is combinational and has no dependency on `in_valid`.
- Accept: `in_valid && in_ready` at a rising edge.
  - `D` <= `in_data`.
  - State <= SETUP, `ph` <= `SETUP_CYC`-1.
- SETUP:
  - `en`=0.
  - When `ph`==0: state <= PULSE, `ph` <= `PULSE_CYC`-1.
  - Otherwise `ph` decrements.
- PULSE:
  - `en`=1.
  - When `ph`==0: state <= HOLD, `ph` <= `HOLD_CYC`-1.
- HOLD:
  - `en`=0, `D` unchanged.
  - When `ph`==0: state <= IDLE and `load_count` increments, wrapping 255 to 0.
- IDLE:
  - `en`=0.
  - `D` retains the last loaded word; it is not cleared.
- `busy` = (state != IDLE).
- `D` is written only on accept. `D` is constant from SETUP through HOLD.
- `in_data` and `in_valid` are ignored while `in_ready`=0. No buffering is done; upstream must hold `in_valid`.
- `en` and `D` are registered outputs, decoded from state into flops. There are no combinational glitches on `en`.
- Parameter values outside 1..15 are illegal. Behaviour with illegal values is unspecified.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State=IDLE, `ph`=0, `D`=0, `en`=0, `busy`=0, `load_count`=0, `in_ready`=0.
  - `rd_err`=0 when present.
- First accept is possible on the first rising edge with `rst_n` high.
- Accept at edge N:
  - `D` is valid from N.
  - `en` is high from N+`SETUP_CYC` to N+`SETUP_CYC`+`PULSE_CYC`.
  - State returns to IDLE at N+S+P+H. `in_ready` is 1 in that cycle.
- Maximum throughput is one word per S+P+H+1 cycles. With defaults, that is one word per 4 cycles.
- Reset mid-sequence:
  - `en` drops to 0 and `D` goes to 0 immediately.
  - `load_count` is not incremented for the aborted load.
  - The latch keeps whatever it captured.
- Reset and accept on the same edge: reset wins and nothing is accepted.

## Configuration
- `DQ4_LOAD_READBACK_EN` defined:
  - Ports `Q` and `rd_err` exist.
  - On the edge that leaves HOLD (last HOLD cycle), `Q` is compared to `D`. A mismatch sets `rd_err`.
  - `rd_err` is sticky until reset. `load_count` still increments on a mismatch.
- Not defined: `Q` and `rd_err` ports are absent, with no readback logic and no extra flops.

## Test plan
- Reset, then drive `in_valid`=1 with `in_data`=0101 (defaults). Expected:
  - `D`=0101 at edge 1.
  - `en`=1 only in the cycle after edge 2.
  - IDLE at edge 4.
  - `load_count`=1.
- Hold `in_valid` high with 0000, 0001, … 1111 back-to-back. Expected:
  - Accepts exactly every 4 cycles.
  - 16 loads; `load_count`=16.
  - `D` never changes while `en`=1.
- Set `SETUP_CYC`=3, `PULSE_CYC`=2, `HOLD_CYC`=2 and load 1010. Expected:
  - `en` high for exactly 2 cycles starting 3 cycles after accept.
  - `in_ready` low for 7 cycles.
- Assert `rst_n`=0 while `en`=1. Expected:
  - `en`=0 and `D`=0000 immediately, before the next edge.
  - `load_count` unchanged.
  - After release, a new word 1100 loads normally.
- Run 256 loads. Expected: `load_count` wraps to 0.
- With `DQ4_LOAD_READBACK_EN`: load 0011, then force `Q` to 0010 during HOLD. Expected:
  - `rd_err`=1 and it stays 1 through later correct loads.
  - `rd_err` clears only on reset.

Source files
------------

// File: rtl/dq4_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dq4_load_ctrl
//  Description : Load sequencer for the 4-bit D-latch array. Accepts one word
//                over valid/ready, drives it on D, then gives en a setup,
//                pulse and hold window. Optional readback compare of the
//                latch outputs is enabled with DQ4_LOAD_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dq4_load_ctrl #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] in_data,
    output logic             in_ready,
    output logic [0:WIDTH-1] D,
    output logic             en,
    output logic             busy,
    output logic [7:0]       load_count
`ifdef DQ4_LOAD_READBACK_EN
    ,
    input  logic [0:WIDTH-1] Q,
    output logic             rd_err
`endif
);

    // Phase counter reload values; each state lasts (value + 1) cycles.
    localparam logic [3:0] c_setup_ph = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_pulse_ph = 4'(PULSE_CYC - 1);
    localparam logic [3:0] c_hold_ph  = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [3:0]         r_ph;
    logic [0:WIDTH-1]   r_d;
    logic               r_en;
    logic [7:0]         r_load_count;

    // Ready is held low during reset so nothing can be accepted then.
    assign in_ready   = (r_state == IDLE) && rst_n;
    assign busy       = (r_state != IDLE);
    assign D          = r_d;
    assign en         = r_en;
    assign load_count = r_load_count;

    // Sequencer: en is a flop set on entry to PULSE and cleared on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ph         <= 4'd0;
            r_d          <= '0;
            r_en         <= 1'b0;
            r_load_count <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_en <= 1'b0;
                    if (in_valid) begin
                        r_d     <= in_data;
                        r_state <= SETUP;
                        r_ph    <= c_setup_ph;
                    end
                end
                SETUP: begin
                    if (r_ph == 4'd0) begin
                        r_state <= PULSE;
                        r_ph    <= c_pulse_ph;
                        r_en    <= 1'b1;
                    end else begin
                        r_ph <= r_ph - 4'd1;
                    end
                end
                PULSE: begin
                    if (r_ph == 4'd0) begin
                        r_state <= HOLD;
                        r_ph    <= c_hold_ph;
                        r_en    <= 1'b0;
                    end else begin
                        r_ph <= r_ph - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_ph == 4'd0) begin
                        r_state      <= IDLE;
                        r_load_count <= r_load_count + 8'd1;
                    end else begin
                        r_ph <= r_ph - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ph    <= 4'd0;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DQ4_LOAD_READBACK_EN
    logic r_rd_err;

    assign rd_err = r_rd_err;

    // Sticky readback flag: compare latch outputs on the last HOLD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_err <= 1'b0;
        end else if ((r_state == HOLD) && (r_ph == 4'd0) && (Q != r_d)) begin
            r_rd_err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
